// File: rtl/kabeta_mem_pkg.sv
// Shared definitions for the data memory access initiator.
//   state_t    : FSM encoding (RMW states exist only with KABETA_BYTE_WRITE_EN)
//   BYTE_LANES : byte lanes per data word
//   ALL_LANES  : byte-enable mask selecting a full-word store
// Optional feature macro: KABETA_BYTE_WRITE_EN
package kabeta_mem_pkg;
  localparam int BYTE_LANES = 4;
  localparam logic [BYTE_LANES-1:0] ALL_LANES = 4'hF;

`ifdef KABETA_BYTE_WRITE_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_RD, ST_RD_WAIT, ST_RSP, ST_RMW_RD, ST_RMW_WAIT, ST_RMW_WR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_RD, ST_RD_WAIT, ST_RSP
  } state_t;
`endif
endpackage

// File: rtl/byte_lane_merge.sv
// Combinational byte-lane merge used by the read-modify-write store path.
//   old_word : word read back from RAM
//   new_word : store data from the request
//   mask     : bit i selects new_word lane i (bits [8i+7:8i])
//   merged   : resulting word to write back
// Only instantiated when KABETA_BYTE_WRITE_EN is defined.
module byte_lane_merge
  import kabeta_mem_pkg::*;
(
  input  logic [BYTE_LANES*8-1:0] old_word,
  input  logic [BYTE_LANES*8-1:0] new_word,
  input  logic [BYTE_LANES-1:0]   mask,
  output logic [BYTE_LANES*8-1:0] merged
);
  for (genvar i = 0; i < BYTE_LANES; i++) begin : g_lane
    assign merged[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
  end
endmodule

// File: rtl/data_mem_access.sv
// CPU-side initiator for the block-RAM data port. Takes one load/store at a
// time over a valid/ready request channel, drives registered RAM controls,
// waits out the fixed read latency and returns load data on a valid/ready
// response channel. Stores never produce a response.
// Ports:
//   Clock, Reset            : rising-edge clock, synchronous active-high reset
//   Req_Valid/Req_Ready     : request handshake (ready only while idle)
//   Req_Write/Addr/WData    : store flag, word address, store data
//   Req_ByteEn              : store byte lanes (KABETA_BYTE_WRITE_EN only)
//   Rsp_Valid/Rsp_Ready     : load response handshake, Rsp_RData payload
//   Mem_Addr/En_R/En_W      : RAM word address and enables
//   Mem_Data_W/Mem_Data_R   : RAM write / read data
// Optional feature macro: KABETA_BYTE_WRITE_EN (partial stores via RMW).
module data_mem_access
  import kabeta_mem_pkg::*;
#(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Write,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_WData,
`ifdef KABETA_BYTE_WRITE_EN
  input  logic [3:0]        Req_ByteEn,
`endif
  output logic              Rsp_Valid,
  input  logic              Rsp_Ready,
  output logic [DATA_W-1:0] Rsp_RData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic              Mem_En_R,
  output logic              Mem_En_W,
  output logic [DATA_W-1:0] Mem_Data_W,
  input  logic [DATA_W-1:0] Mem_Data_R
);
  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

`ifdef KABETA_BYTE_WRITE_EN
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] merged;

  byte_lane_merge u_merge (
    .old_word (Mem_Data_R),
    .new_word (wdata_q),
    .mask     (be_q),
    .merged   (merged)
  );
`endif

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      Req_Ready  <= 1'b1;
      Rsp_Valid  <= 1'b0;
      Rsp_RData  <= '0;
      Mem_En_R   <= 1'b0;
      Mem_En_W   <= 1'b0;
      Mem_Addr   <= '0;
      Mem_Data_W <= '0;
`ifdef KABETA_BYTE_WRITE_EN
      wdata_q    <= '0;
      be_q       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // Req_Ready is high throughout IDLE, so Req_Valid alone means accept.
          if (Req_Valid) begin
            if (!Req_Write) begin
              state     <= ST_RD;
              Mem_En_R  <= 1'b1;
              Mem_Addr  <= Req_Addr;
              Req_Ready <= 1'b0;
            end
`ifdef KABETA_BYTE_WRITE_EN
            else if (Req_ByteEn == '0) begin
              // Empty mask: nothing to write, stay ready.
            end else if (Req_ByteEn != ALL_LANES) begin
              state     <= ST_RMW_RD;
              Mem_En_R  <= 1'b1;
              Mem_Addr  <= Req_Addr;
              wdata_q   <= Req_WData;
              be_q      <= Req_ByteEn;
              Req_Ready <= 1'b0;
            end
`endif
            else begin
              state      <= ST_WR;
              Mem_En_W   <= 1'b1;
              Mem_Addr   <= Req_Addr;
              Mem_Data_W <= Req_WData;
              Req_Ready  <= 1'b0;
            end
          end
        end
        ST_WR: begin
          Mem_En_W  <= 1'b0;
          Req_Ready <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_RD: begin
          Mem_En_R <= 1'b0;
          cnt      <= CNT_W'(RD_LAT);
          state    <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Last wait cycle is the one in which RAM data is valid.
          if (cnt == CNT_W'(1)) begin
            Rsp_RData <= Mem_Data_R;
            Rsp_Valid <= 1'b1;
            state     <= ST_RSP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RSP: begin
          if (Rsp_Ready) begin
            Rsp_Valid <= 1'b0;
            Req_Ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
`ifdef KABETA_BYTE_WRITE_EN
        ST_RMW_RD: begin
          Mem_En_R <= 1'b0;
          cnt      <= CNT_W'(RD_LAT);
          state    <= ST_RMW_WAIT;
        end
        ST_RMW_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            Mem_Data_W <= merged;
            Mem_En_W   <= 1'b1;
            state      <= ST_RMW_WR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RMW_WR: begin
          Mem_En_W  <= 1'b0;
          Req_Ready <= 1'b1;
          state     <= ST_IDLE;
        end
`endif
        default: begin
          Mem_En_R  <= 1'b0;
          Mem_En_W  <= 1'b0;
          Req_Ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_access.sv
// Bench for data_mem_access: RAM model with RD_LAT latency, a word-array
// reference memory and a queue of expected load responses.
module tb_data_mem_access;
  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  logic              Clock = 1'b0;
  logic              Reset;
  logic              Req_Valid, Req_Ready, Req_Write;
  logic [ADDR_W-1:0] Req_Addr;
  logic [DATA_W-1:0] Req_WData;
  logic [3:0]        be_sig;
  logic              Rsp_Valid, Rsp_Ready;
  logic [DATA_W-1:0] Rsp_RData;
  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_En_R, Mem_En_W;
  logic [DATA_W-1:0] Mem_Data_W, Mem_Data_R;

  data_mem_access #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_Write  (Req_Write),
    .Req_Addr   (Req_Addr),
    .Req_WData  (Req_WData),
`ifdef KABETA_BYTE_WRITE_EN
    .Req_ByteEn (be_sig),
`endif
    .Rsp_Valid  (Rsp_Valid),
    .Rsp_Ready  (Rsp_Ready),
    .Rsp_RData  (Rsp_RData),
    .Mem_Addr   (Mem_Addr),
    .Mem_En_R   (Mem_En_R),
    .Mem_En_W   (Mem_En_W),
    .Mem_Data_W (Mem_Data_W),
    .Mem_Data_R (Mem_Data_R)
  );

  always #5 Clock = ~Clock;

  int          checks = 0;
  int          failures = 0;
  bit          rand_rsp = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [64];
  logic [31:0] ram [64];
  logic [31:0] rd_pipe [RD_LAT];
  logic [31:0] held;

  // RAM: write on enable, read data emerges RD_LAT edges after the enable edge.
  always @(posedge Clock) begin
    if (Mem_En_W) ram[Mem_Addr[5:0]] <= Mem_Data_W;
    rd_pipe[0] <= Mem_En_R ? ram[Mem_Addr[5:0]] : 32'hBADBAD00;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign Mem_Data_R = rd_pipe[RD_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock); #1;
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] b);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  // Present a request, wait for acceptance, update the reference, and return
  // in the cycle after the accept edge with Req_Valid still high.
  task automatic issue(input bit wr, input logic [5:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    Req_Valid = 1'b1; Req_Write = wr; Req_Addr = ADDR_W'(a); Req_WData = d; be_sig = b;
    for (int n = 0; n < 64 && Req_Ready !== 1'b1; n++) begin
      if (rand_rsp) Rsp_Ready = 1'($urandom_range(0, 1));
      tick();
    end
    chk("accept_wait", 32'(Req_Ready), 32'd1);
    if (!wr) exp_q.push_back(model[a]);
`ifdef KABETA_BYTE_WRITE_EN
    else if (b != 4'h0) model[a] = lane_merge(model[a], d, b);
`else
    else model[a] = d;
`endif
    if (rand_rsp) Rsp_Ready = 1'($urandom_range(0, 1));
    tick();
  endtask

  task automatic wait_idle();
    Req_Valid = 1'b0; Rsp_Ready = 1'b1;
    for (int n = 0; n < 64 && !(Req_Ready === 1'b1 && exp_q.size() == 0); n++) tick();
    chk("drain_ready", 32'(Req_Ready), 32'd1);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  // Response scoreboard and enable-exclusivity check, sampled mid-cycle.
  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      chk("en_overlap", 32'(Mem_En_R & Mem_En_W), 32'd0);
      if (Rsp_Valid === 1'b1 && Rsp_Ready === 1'b1) begin
        if (exp_q.size() == 0) chk("spurious_rsp", 32'(Rsp_Valid), 32'd0);
        else chk("rsp_data", Rsp_RData, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: run did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; Req_Valid = 1'b0; Req_Write = 1'b0; Req_Addr = '0; Req_WData = '0;
    be_sig = 4'hF; Rsp_Ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 32'(Req_Ready), 32'd1);
    chk("rst_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("rst_rsp_rdata", Rsp_RData, 32'd0);
    chk("rst_en_r", 32'(Mem_En_R), 32'd0);
    chk("rst_en_w", 32'(Mem_En_W), 32'd0);
    chk("rst_addr", 32'(Mem_Addr), 32'd0);
    chk("rst_wdata", Mem_Data_W, 32'd0);
    Reset = 1'b0;
    tick();

    // Fill the RAM with back-to-back full-word stores.
    for (int i = 0; i < 64; i++) issue(1'b1, 6'(i), $urandom, 4'hF);
    wait_idle();

    // Store timing.
    issue(1'b1, 6'h10, 32'hDEADBEEF, 4'hF);
    Req_Valid = 1'b0;
    chk("st_en_w", 32'(Mem_En_W), 32'd1);
    chk("st_en_r", 32'(Mem_En_R), 32'd0);
    chk("st_addr", 32'(Mem_Addr), 32'h10);
    chk("st_wdata", Mem_Data_W, 32'hDEADBEEF);
    chk("st_busy", 32'(Req_Ready), 32'd0);
    tick();
    chk("st_en_w_off", 32'(Mem_En_W), 32'd0);
    chk("st_ready_t2", 32'(Req_Ready), 32'd1);
    chk("st_ram", ram[6'h10], 32'hDEADBEEF);

    // Load timing with an always-ready consumer.
    Rsp_Ready = 1'b1;
    issue(1'b0, 6'h10, 32'h0, 4'hF);
    Req_Valid = 1'b0;
    chk("ld_en_r", 32'(Mem_En_R), 32'd1);
    chk("ld_addr", 32'(Mem_Addr), 32'h10);
    for (int i = 0; i < RD_LAT; i++) begin
      tick();
      chk("ld_en_r_off", 32'(Mem_En_R), 32'd0);
      chk("ld_rsp_early", 32'(Rsp_Valid), 32'd0);
    end
    tick();
    chk("ld_rsp_valid", 32'(Rsp_Valid), 32'd1);
    chk("ld_rsp_data", Rsp_RData, 32'hDEADBEEF);
    tick();
    chk("ld_rsp_drop", 32'(Rsp_Valid), 32'd0);
    chk("ld_ready_back", 32'(Req_Ready), 32'd1);

    // Stalled consumer; request-side noise while busy must be ignored.
    Rsp_Ready = 1'b0;
    issue(1'b0, 6'h05, 32'h0, 4'hF);
    for (int n = 0; n < 16 && Rsp_Valid !== 1'b1; n++) tick();
    chk("stall_valid", 32'(Rsp_Valid), 32'd1);
    held = Rsp_RData;
    chk("stall_data", held, model[5]);
    for (int i = 0; i < 5; i++) begin
      Req_Write = 1'b1; Req_WData = $urandom;
      tick();
      chk("stall_hold_v", 32'(Rsp_Valid), 32'd1);
      chk("stall_hold_d", Rsp_RData, held);
      chk("stall_busy", 32'(Req_Ready), 32'd0);
    end
    Req_Valid = 1'b0; Rsp_Ready = 1'b1;
    tick();
    chk("stall_clear", 32'(Rsp_Valid), 32'd0);
    chk("stall_ready", 32'(Req_Ready), 32'd1);
    chk("stall_no_wr", ram[5], model[5]);

    // Random back-to-back traffic with Req_Valid held high.
    rand_rsp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] b;
      b = 4'hF;
`ifdef KABETA_BYTE_WRITE_EN
      case ($urandom_range(0, 2))
        0: b = 4'hF;
        1: b = 4'h0;
        default: b = 4'($urandom);
      endcase
`endif
      issue(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom, b);
    end
    rand_rsp = 1'b0;
    wait_idle();

    // Reset during the read wait: the load must vanish.
    issue(1'b0, 6'h21, 32'h0, 4'hF);
    Req_Valid = 1'b0;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    exp_q.delete();
    chk("mr_req_ready", 32'(Req_Ready), 32'd1);
    chk("mr_rsp_valid", 32'(Rsp_Valid), 32'd0);
    chk("mr_rsp_rdata", Rsp_RData, 32'd0);
    chk("mr_en_r", 32'(Mem_En_R), 32'd0);
    chk("mr_en_w", 32'(Mem_En_W), 32'd0);
    chk("mr_addr", 32'(Mem_Addr), 32'd0);
    chk("mr_wdata", Mem_Data_W, 32'd0);
    Rsp_Ready = 1'b1;
    for (int i = 0; i < RD_LAT + 4; i++) begin
      tick();
      chk("mr_no_rsp", 32'(Rsp_Valid), 32'd0);
    end

`ifdef KABETA_BYTE_WRITE_EN
    // Partial store merges lanes 0 and 2; empty mask touches nothing.
    issue(1'b1, 6'h20, 32'h11223344, 4'hF);
    issue(1'b1, 6'h20, 32'hAABBCCDD, 4'b0101);
    wait_idle();
    chk("rmw_word", ram[6'h20], 32'h11BB33DD);
    issue(1'b1, 6'h20, 32'hFFFFFFFF, 4'h0);
    Req_Valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("m0_en_w", 32'(Mem_En_W), 32'd0);
      chk("m0_en_r", 32'(Mem_En_R), 32'd0);
      chk("m0_ready", 32'(Req_Ready), 32'd1);
      tick();
    end
    chk("m0_word", ram[6'h20], 32'h11BB33DD);
    issue(1'b0, 6'h20, 32'h0, 4'hF);
    wait_idle();
`endif

    for (int i = 0; i < 64; i++) chk($sformatf("ram_word_%0d", i), ram[i], model[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
